// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Command-side sequencer for the 4-bit-operand accumulator ALU. Up to
//   DEPTH (Function, Data) instructions are loaded through a valid/ready
//   port. A Start pulse then clears the ALU, issues one instruction per
//   cycle, captures the final 8-bit accumulator and pulses Done.
//
// Ports
//   Clock        rising-edge clock for all state
//   Reset_b      synchronous active-low reset
//   InValid      instruction load request
//   InFunction   opcode to store (00 add, 01 mul, 10 shl, 11 hold)
//   InData       operand to store
//   InReady      load accepted this cycle when high together with InValid
//   Start        begin executing the stored program
//   AluFunction  opcode driven to the ALU
//   AluData      operand driven to the ALU
//   AluClear     one-cycle clear of the ALU accumulator
//   AluResult    registered ALU accumulator value
//   Result       captured final accumulator value
//   Done         one-cycle pulse in the cycle after Result is updated
//   Busy         high in every state except IDLE
//   dbg_state    current FSM state, for observation only
//
// Load handshake: a load happens at a rising edge where InValid and
// InReady are both high. InReady only depends on state and count, never
// on InValid. Outside IDLE, InReady is low and InValid/Start are ignored.
module alu_sequencer (
    input  logic       Clock,
    input  logic       Reset_b,
    input  logic       InValid,
    input  logic [1:0] InFunction,
    input  logic [3:0] InData,
    output logic       InReady,
    input  logic       Start,
    output logic [1:0] AluFunction,
    output logic [3:0] AluData,
    output logic       AluClear,
    input  logic [7:0] AluResult,
    output logic [7:0] Result,
    output logic       Done,
    output logic       Busy,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] DEPTH   = 4'd8;
    localparam logic [1:0] FN_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] index_q, index_d;

    // Outputs are registered: their _d values describe the cycle that
    // follows the coming edge, so they are decoded from state_d/index_d.
    logic       in_ready_q, in_ready_d;
    logic [1:0] alu_function_q, alu_function_d;
    logic [3:0] alu_data_q, alu_data_d;
    logic       alu_clear_q, alu_clear_d;
    logic [7:0] result_q, result_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    // Program memory has no reset; only count decides which entries are live.
    logic [5:0] mem_q [0:7];
    logic       mem_we;
    logic [5:0] mem_rd;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        index_d        = index_q;
        result_d       = result_q;
        done_d         = 1'b0;
        mem_we         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (InValid && (count_q < DEPTH)) begin
                    mem_we  = 1'b1;
                    count_d = count_q + 4'd1;
                end else if (Start && !InValid) begin
                    // A simultaneous InValid wins over Start, even when
                    // the load itself is dropped because memory is full.
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                index_d = 4'd0;
                state_d = (count_q != 4'd0) ? ST_RUN : ST_CAPTURE;
            end
            ST_RUN: begin
                index_d = index_q + 4'd1;
                if (index_q == count_q - 4'd1) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                result_d = AluResult;
                done_d   = 1'b1;
                count_d  = 4'd0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_rd         = mem_q[index_d[2:0]];
        in_ready_d     = (state_d == ST_IDLE) && (count_d < DEPTH);
        busy_d         = (state_d != ST_IDLE);
        alu_clear_d    = (state_d == ST_CLEAR);
        alu_function_d = FN_HOLD;
        alu_data_d     = 4'd0;
        if (state_d == ST_RUN) begin
            alu_function_d = mem_rd[5:4];
            alu_data_d     = mem_rd[3:0];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state_q        <= ST_IDLE;
            count_q        <= 4'd0;
            index_q        <= 4'd0;
            in_ready_q     <= 1'b1;
            alu_function_q <= FN_HOLD;
            alu_data_q     <= 4'd0;
            alu_clear_q    <= 1'b0;
            result_q       <= 8'h00;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            index_q        <= index_d;
            in_ready_q     <= in_ready_d;
            alu_function_q <= alu_function_d;
            alu_data_q     <= alu_data_d;
            alu_clear_q    <= alu_clear_d;
            result_q       <= result_d;
            done_q         <= done_d;
            busy_q         <= busy_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[count_q[2:0]] <= {InFunction, InData};
        end
    end

    assign InReady     = in_ready_q;
    assign AluFunction = alu_function_q;
    assign AluData     = alu_data_q;
    assign AluClear    = alu_clear_q;
    assign Result      = result_q;
    assign Done        = done_q;
    assign Busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       Clock;
  logic       Reset_b;
  logic       InValid;
  logic [1:0] InFunction;
  logic [3:0] InData;
  logic       InReady;
  logic       Start;
  logic [1:0] AluFunction;
  logic [3:0] AluData;
  logic       AluClear;
  logic [7:0] AluResult;
  logic [7:0] Result;
  logic       Done;
  logic       Busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  // bench-side copy of the loaded program
  logic [1:0] prog_fn[$];
  logic [3:0] prog_dat[$];

  alu_sequencer dut (
    .Clock(Clock),
    .Reset_b(Reset_b),
    .InValid(InValid),
    .InFunction(InFunction),
    .InData(InData),
    .InReady(InReady),
    .Start(Start),
    .AluFunction(AluFunction),
    .AluData(AluData),
    .AluClear(AluClear),
    .AluResult(AluResult),
    .Result(Result),
    .Done(Done),
    .Busy(Busy),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // behavioural accumulator ALU driven by the sequencer
  always_ff @(posedge Clock) begin
    if (!Reset_b || AluClear) AluResult <= 8'h00;
    else begin
      case (AluFunction)
        2'b00: AluResult <= {4'h0, AluResult[3:0]} + {4'h0, AluData};
        2'b01: AluResult <= {4'h0, AluResult[3:0]} * {4'h0, AluData};
        2'b10: AluResult <= {4'h0, AluResult[3:0]} << AluData;
        default: AluResult <= AluResult;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_run();
    logic [7:0] acc;
    logic [7:0] a;
    logic [7:0] d;
    acc = 8'h00;
    for (int i = 0; i < prog_fn.size(); i++) begin
      a = {4'h0, acc[3:0]};
      d = {4'h0, prog_dat[i]};
      case (prog_fn[i])
        2'b00: acc = a + d;
        2'b01: acc = a * d;
        2'b10: acc = a << d;
        default: acc = acc;
      endcase
    end
    return acc;
  endfunction

  // driver: one load request, held across a single rising edge
  task automatic load(input logic [1:0] fn, input logic [3:0] dat);
    InValid = 1'b1;
    InFunction = fn;
    InData = dat;
    if (prog_fn.size() < 8) begin
      prog_fn.push_back(fn);
      prog_dat.push_back(dat);
    end
    @(negedge Clock);
    InValid = 1'b0;
  endtask

  // driver + per-cycle checks of one program execution; noise drives
  // InValid/Start while the block is busy
  task automatic run(input string tag, input logic [7:0] exp_res, input bit noise);
    int n;
    logic [7:0] e;
    n = prog_fn.size();
    exp_q.push_back(exp_res);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    for (int k = 1; k <= n + 4; k++) begin
      chk({tag, " busy"}, Busy, (k <= n + 2));
      chk({tag, " clear"}, AluClear, (k == 1));
      chk({tag, " done"}, Done, (k == n + 3));
      if (k >= 2 && k <= n + 1) begin
        chk({tag, " fn"}, AluFunction, prog_fn[k-2]);
        chk({tag, " data"}, AluData, prog_dat[k-2]);
      end else begin
        chk({tag, " fn_hold"}, AluFunction, 2'b11);
        chk({tag, " data0"}, AluData, 4'h0);
      end
      if (k == n + 3) begin
        chk({tag, " ready_after"}, InReady, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({tag, " result"}, Result, e);
        end
      end
      if (noise && k < n + 2) begin
        InValid = 1'b1;
        InFunction = 2'b00;
        InData = 4'h7;
        Start = 1'b1;
      end else begin
        InValid = 1'b0;
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    prog_fn.delete();
    prog_dat.delete();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " result"}, Result, 8'h00);
    chk({tag, " done"}, Done, 1'b0);
    chk({tag, " busy"}, Busy, 1'b0);
    chk({tag, " clear"}, AluClear, 1'b0);
    chk({tag, " fn"}, AluFunction, 2'b11);
    chk({tag, " data"}, AluData, 4'h0);
    chk({tag, " ready"}, InReady, 1'b1);
  endtask

  initial begin
    logic [1:0] rf;
    logic [3:0] rd;
    Reset_b = 1'b0;
    InValid = 1'b0;
    InFunction = 2'b00;
    InData = 4'h0;
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk_reset_values("reset");
    Reset_b = 1'b1;
    @(negedge Clock);

    // basic program: 3, *5, <<1 -> 0x1E
    load(2'b00, 4'd3);
    load(2'b01, 4'd5);
    load(2'b10, 4'd1);
    run("basic", 8'h1E, 1'b0);

    // only the low nibble of the accumulator feeds the next step
    load(2'b00, 4'd9);
    load(2'b00, 4'd9);
    load(2'b00, 4'd9);
    run("wrap", 8'h0B, 1'b0);

    // fill: ninth load must see InReady low and be dropped
    for (int i = 0; i < 9; i++) begin
      chk("fill ready", InReady, (i < 8));
      load(2'b00, 4'd1);
    end
    chk("full ready", InReady, 1'b0);
    run("fill", 8'h08, 1'b0);

    // empty program
    run("empty", 8'h00, 1'b0);

    // Start together with InValid: load wins, block stays idle
    InValid = 1'b1;
    InFunction = 2'b00;
    InData = 4'd6;
    Start = 1'b1;
    prog_fn.push_back(2'b00);
    prog_dat.push_back(4'd6);
    @(negedge Clock);
    InValid = 1'b0;
    Start = 1'b0;
    chk("same_cycle busy", Busy, 1'b0);
    chk("same_cycle clear", AluClear, 1'b0);
    run("same_cycle", 8'h06, 1'b0);

    // reset in the middle of RUN of a 4-entry program
    load(2'b00, 4'd1);
    load(2'b00, 4'd2);
    load(2'b00, 4'd3);
    load(2'b00, 4'd4);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk("midrun busy", Busy, 1'b1);
    Reset_b = 1'b0;
    @(negedge Clock);
    chk_reset_values("midrun_reset");
    Reset_b = 1'b1;
    prog_fn.delete();
    prog_dat.delete();
    @(negedge Clock);
    chk("after_reset done", Done, 1'b0);
    run("after_reset", 8'h00, 1'b1);
    // noise while busy must neither load nor restart
    for (int i = 0; i < 3; i++) begin
      chk("quiet done", Done, 1'b0);
      chk("quiet busy", Busy, 1'b0);
      @(negedge Clock);
    end
    load(2'b00, 4'd5);
    run("post_noise", 8'h05, 1'b0);

    // hold instruction leaves the accumulator alone
    load(2'b11, 4'd7);
    load(2'b00, 4'd4);
    run("hold", 8'h04, 1'b0);

    // randomised programs against the bench model
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        rf = 2'($urandom_range(0, 3));
        rd = 4'($urandom_range(0, 15));
        load(rf, rd);
      end
      run("random", model_run(), 1'b0);
    end

    chk("queue empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program-driven sequencer for the 4-bit-operand accumulator ALU. It sits on the command side of that ALU and drives the ALU's Function/Data inputs. Software-side logic loads up to 8 (Function, Data) instructions through a valid/ready port, then pulses Start. The block clears the ALU, issues one instruction per cycle, captures the final 8-bit accumulator value and reports it with a one-cycle Done pulse.

## Interface
- DEPTH, 8, program memory entries (count register is 4 bits wide).
- Clock  in  1  rising-edge clock for all state.
- Reset_b  in  1  synchronous, active-low reset; sampled on rising Clock edge.
- InValid  in  1  instruction load request.
- InFunction  in  2  opcode to store: 00 add, 01 mul, 10 shift-left, 11 hold.
- InData  in  4  operand to store.
- InReady  out  1  high when a load is accepted this cycle.
- Start  in  1  begin execution of the stored program.
- AluFunction  out  2  opcode driven to the ALU.
- AluData  out  4  operand driven to the ALU.
- AluClear  out  1  one-cycle request that clears the ALU accumulator to 0.
- AluResult  in  8  registered ALU accumulator output.
- Result  out  8  captured final accumulator value.
- Done  out  1  one-cycle pulse when Result is updated.
- Busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, RUN, CAPTURE.
- IDLE:
  - InReady = (count < DEPTH).
  - InValid && InReady: write {InFunction, InData} to mem[count], count += 1.
  - Start && !InValid: go to CLEAR.
  - Start && InValid in the same cycle: the load is performed and Start is ignored.
- CLEAR: one cycle. AluClear = 1, AluFunction = 11, AluData = 0, index = 0. Next state is RUN if count > 0, else CAPTURE.
- RUN:
  - Each cycle drives AluFunction/AluData = mem[index], then index += 1.
  - After index == count-1 is driven, go to CAPTURE.
- CAPTURE: one cycle. AluFunction = 11 (hold). Result <= AluResult at the closing edge; Done = 1 in the next cycle. Next state IDLE with count = 0, so the program is consumed.
- Outside CLEAR/RUN: AluFunction = 11, AluData = 0, AluClear = 0.
- Outside IDLE: InReady = 0; InValid and Start are ignored.
- ALU model used for checking:
  - acc_next = f(acc[3:0], Data), 8-bit.
  - add: zero-extended sum.
  - mul: 4x4 product.
  - shl: acc[3:0] << Data, truncated to 8 bits.
  - hold: acc unchanged.
- Result holds its value until the next CAPTURE or reset.

## Timing
- Reset (Reset_b low at an edge):
  - state = IDLE, count = 0, index = 0.
  - Result = 0x00, Done = 0, Busy = 0, AluClear = 0, AluFunction = 11, AluData = 0, InReady = 1.
  - Reset mid-RUN aborts execution and discards the program.
- Start accepted at edge E0. Cycle k is the interval after edge Ek:
  - CLEAR in cycle 1.
  - RUN in cycles 2..N+1.
  - CAPTURE in cycle N+2.
  - Done high in cycle N+3.
  - IDLE from cycle N+3, with InReady = 1 in that cycle.
- Busy is high in cycles 1..N+2.
- Empty program (N = 0): Result = 0x00 and Done in cycle 3.
- Full: with count = 8, InReady = 0 and a further InValid is dropped with no write.
- Program memory needs no reset; only count is reset.

## Test plan
- Load (00,3), (01,5), (10,1), then Start -> Result = 0x1E, Done high exactly 6 cycles after the Start edge, Busy high for 5 cycles.
- Wrap: load (00,9), (00,9), (00,9), then Start -> Result = 0x0B, since the low nibble of 0x12 is 2 and 2 + 9 = 11.
- Fill: 9 consecutive InValid with (00,1) -> InReady low on the 9th; Start -> Result = 0x08, Done at cycle 11.
- Start with the program empty -> AluClear high in cycle 1, Result = 0x00, Done in cycle 3; InValid and Start asserted in the same cycle -> count increments and Busy stays 0.
- Reset_b low during RUN of a 4-entry program:
  - all outputs at their reset values on the next cycle;
  - a subsequent Start with no loads gives Result = 0x00;
  - Start and InValid asserted while Busy are ignored, so count is unchanged and Done occurs only once.
- Hold check: load (11,7), (00,4), then Start -> AluData = 7 while AluFunction = 11, and Result = 0x04.
